// File: rtl/console_pkg.sv
// Shared constants, state encoding and address helper for the text console.
// Geometry matches the 80x60 text-mode video block.
package console_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 60;
    localparam int ADDR_W = 13;
    localparam int CELLS  = COLS * ROWS;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_SRC  = ADDR_W'(CELLS - COLS - 1);
    localparam logic [ADDR_W-1:0] FILL_BASE = ADDR_W'(CELLS - COLS);

    typedef enum logic [2:0] {
        INIT_CLR,
        IDLE,
        WRITE,
        S_RD,
        S_CAP,
        S_WR,
        S_FILL,
        CLEAR
    } state_t;

    // row*80 as two shifts keeps this a pair of adders
    function automatic logic [ADDR_W-1:0] cell_addr(
        input logic [5:0] row,
        input logic [6:0] col
    );
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        return (r << 6) + (r << 4) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/text_console.sv
// Character-stream terminal engine feeding the text-mode video RAM.
// One FSM owns the bus: cell writes, scroll copy/fill and full clears.
module text_console
    import console_pkg::*;
(
    input  logic              clk_25mhz,
    input  logic              rst_i,
    input  logic [7:0]        char_i,
    input  logic              char_valid_i,
    output logic              char_ready_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [31:0]       dat_o,
    output logic [3:0]        sel_o,
    output logic              we_o,
    output logic              stb_o,
    input  logic              ack_i,
    input  logic [31:0]       dat_i,
    output logic [6:0]        cursor_col_o,
    output logic [5:0]        cursor_row_o,
    output logic              busy_o
);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] adr;
    logic [7:0]        dat;
    logic [6:0]        col;
    logic [5:0]        row;
    logic              stb;
    logic              we;
    logic              unused_dat;

    assign unused_dat   = ^dat_i[31:8];
    assign adr_o        = adr;
    assign dat_o        = {24'h0, dat};
    assign sel_o        = stb ? 4'b0001 : 4'b0000;
    assign we_o         = we;
    assign stb_o        = stb;
    assign cursor_col_o = col;
    assign cursor_row_o = row;
    assign busy_o       = (state != IDLE);
    assign char_ready_o = (state == IDLE);

    always_ff @(posedge clk_25mhz or negedge rst_i) begin
        if (!rst_i) begin
            state <= INIT_CLR;
            cnt   <= '0;
            adr   <= '0;
            dat   <= '0;
            col   <= '0;
            row   <= '0;
            stb   <= 1'b0;
            we    <= 1'b0;
        end else begin
            unique case (state)
                INIT_CLR, CLEAR: begin
                    if (!stb) begin
                        stb <= 1'b1;
                        we  <= 1'b1;
                        adr <= cnt;
                        dat <= BLANK;
                    end else if (ack_i) begin
                        if (cnt == LAST_CELL) begin
                            stb   <= 1'b0;
                            we    <= 1'b0;
                            cnt   <= '0;
                            col   <= '0;
                            row   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                            adr <= cnt + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (char_valid_i) begin
                        case (char_i)
                            CH_CR: col <= '0;
                            CH_LF: begin
                                col <= '0;
                                if (row != LAST_ROW) begin
                                    row <= row + 1'b1;
                                end else begin
                                    state <= S_RD;
                                    cnt   <= '0;
                                    stb   <= 1'b1;
                                    we    <= 1'b0;
                                    adr   <= ROW_STEP;
                                end
                            end
                            CH_BS: if (col != '0) col <= col - 1'b1;
                            CH_FF: begin
                                state <= CLEAR;
                                cnt   <= '0;
                                stb   <= 1'b1;
                                we    <= 1'b1;
                                adr   <= '0;
                                dat   <= BLANK;
                            end
                            default: begin
                                state <= WRITE;
                                stb   <= 1'b1;
                                we    <= 1'b1;
                                adr   <= cell_addr(row, col);
                                dat   <= char_i;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (ack_i) begin
                        stb <= 1'b0;
                        we  <= 1'b0;
                        if (col != LAST_COL) begin
                            col   <= col + 1'b1;
                            state <= IDLE;
                        end else if (row != LAST_ROW) begin
                            col   <= '0;
                            row   <= row + 1'b1;
                            state <= IDLE;
                        end else begin
                            col   <= '0;
                            state <= S_RD;
                            cnt   <= '0;
                            stb   <= 1'b1;
                            adr   <= ROW_STEP;
                        end
                    end
                end
                S_RD: begin
                    if (ack_i) begin
                        stb   <= 1'b0;
                        state <= S_CAP;
                    end
                end
                // read data lands one cycle after the acked read
                S_CAP: begin
                    stb   <= 1'b1;
                    we    <= 1'b1;
                    adr   <= cnt;
                    dat   <= dat_i[7:0];
                    state <= S_WR;
                end
                S_WR: begin
                    if (ack_i) begin
                        if (cnt == LAST_SRC) begin
                            cnt   <= FILL_BASE;
                            adr   <= FILL_BASE;
                            dat   <= BLANK;
                            state <= S_FILL;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            adr   <= cnt + 1'b1 + ROW_STEP;
                            we    <= 1'b0;
                            state <= S_RD;
                        end
                    end
                end
                S_FILL: begin
                    if (ack_i) begin
                        if (cnt == LAST_CELL) begin
                            stb   <= 1'b0;
                            we    <= 1'b0;
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                            adr <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Randomized bench for text_console against a screen/cursor model.
// RAM slave acks every strobe unless held, with a registered read port.
module tb_text_console;

    logic        clk_25mhz = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  char_i = 8'h00;
    logic        char_valid_i = 1'b0;
    logic        char_ready_o;
    logic [12:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        stb_o;
    logic        ack_i;
    logic [6:0]  cursor_col_o;
    logic [5:0]  cursor_row_o;
    logic        busy_o;

    text_console dut (
        .clk_25mhz    (clk_25mhz),
        .rst_i        (rst_i),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .sel_o        (sel_o),
        .we_o         (we_o),
        .stb_o        (stb_o),
        .ack_i        (ack_i),
        .dat_i        (dat_i),
        .cursor_col_o (cursor_col_o),
        .cursor_row_o (cursor_row_o),
        .busy_o       (busy_o)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    // RAM slave
    logic       ack_hold = 1'b0;
    logic [7:0] rd_q = 8'h00;
    logic [7:0] mem [4800];
    int         acc_cnt = 0;
    int         sel_err = 0;
    int         wr_adr_q [$];
    logic [7:0] wr_dat_q [$];

    assign ack_i = stb_o & ~ack_hold;
    assign dat_i = {24'h0, rd_q};

    always @(posedge clk_25mhz) begin
        if (stb_o) begin
            acc_cnt++;
            if (sel_o != 4'b0001 || dat_o[31:8] != 24'h0) sel_err++;
            if (ack_i && adr_o < 13'd4800) begin
                if (we_o) begin
                    mem[adr_o] = dat_o[7:0];
                    wr_adr_q.push_back(int'(adr_o));
                    wr_dat_q.push_back(dat_o[7:0]);
                end else begin
                    rd_q <= mem[adr_o];
                end
            end
        end else if (sel_o != 4'b0000) begin
            sel_err++;
        end
    end

    // reference model
    logic [7:0] scr [4800];
    int         m_col = 0;
    int         m_row = 0;

    task automatic m_adv();
        if (m_row < 59) begin
            m_row++;
        end else begin
            for (int i = 0; i < 4720; i++) scr[i] = scr[i + 80];
            for (int i = 4720; i < 4800; i++) scr[i] = 8'h20;
        end
    endtask

    task automatic m_blank();
        for (int i = 0; i < 4800; i++) scr[i] = 8'h20;
        m_col = 0;
        m_row = 0;
    endtask

    task automatic model_put(input logic [7:0] b);
        case (b)
            8'h0D: m_col = 0;
            8'h0A: begin
                m_col = 0;
                m_adv();
            end
            8'h08: if (m_col > 0) m_col--;
            8'h0C: m_blank();
            default: begin
                scr[m_row * 80 + m_col] = b;
                if (m_col == 79) begin
                    m_col = 0;
                    m_adv();
                end else begin
                    m_col++;
                end
            end
        endcase
    endtask

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_cur(input string tag);
        chk({tag, "_col"}, int'(cursor_col_o), m_col);
        chk({tag, "_row"}, int'(cursor_row_o), m_row);
    endtask

    task automatic chk_scr(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 4800; i++) if (mem[i] !== scr[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk_25mhz);
        char_i = b;
        char_valid_i = 1'b1;
        while (!char_ready_o && n < 20000) begin
            @(negedge clk_25mhz);
            n++;
        end
        if (n >= 20000) chk("send_tmo", int'(char_ready_o), 1);
        @(posedge clk_25mhz);
        #1;
        char_valid_i = 1'b0;
        model_put(b);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk_25mhz);
        while (busy_o && n < 30000) begin
            n++;
            @(negedge clk_25mhz);
        end
        if (n >= 30000) chk("idle_tmo", int'(busy_o), 0);
    endtask

    task automatic chk_clear(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_wr"}, wr_adr_q.size(), 4800);
        for (int i = 0; i < wr_adr_q.size(); i++)
            if (wr_adr_q[i] != i || wr_dat_q[i] != 8'h20) bad++;
        chk({tag, "_order"}, bad, 0);
    endtask

    initial begin
        int n, a0, c0, r0, nq, acc0, bad;
        logic [7:0] b;
        for (int i = 0; i < 4800; i++) begin
            mem[i] = 8'h00;
            scr[i] = 8'h00;
        end

        // 1: reset state and power-up clear
        repeat (3) @(negedge clk_25mhz);
        chk("rst_stb", int'(stb_o), 0);
        chk("rst_we", int'(we_o), 0);
        chk("rst_adr", int'(adr_o), 0);
        chk("rst_ready", int'(char_ready_o), 0);
        chk("rst_busy", int'(busy_o), 1);
        chk_cur("rst");
        wr_adr_q.delete();
        wr_dat_q.delete();
        rst_i = 1'b1;
        wait_idle(n);
        m_blank();
        chk_clear("init");
        chk("init_ready", int'(char_ready_o), 1);
        chk("init_busy", int'(busy_o), 0);
        chk_cur("init");

        // 2: single write and control codes
        wr_adr_q.delete();
        wr_dat_q.delete();
        send(8'h41);
        wait_idle(n);
        chk("a_cyc", n, 1);
        chk("a_wr", wr_adr_q.size(), 1);
        chk("a_adr", wr_adr_q[0], 0);
        chk("a_dat", int'(wr_dat_q[0]), 'h41);
        chk_cur("a");
        send(8'h0D);
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) begin
            send(8'h20);
            wait_idle(n);
        end
        send(8'h42);
        wait_idle(n);
        chk("b_adr", wr_adr_q[$], 165);
        chk("b_dat", int'(wr_dat_q[$]), 'h42);
        chk_cur("b");

        // 3: form feed, line wrap, backspace
        send(8'h0C);
        wait_idle(n);
        chk("ff1_cyc", n, 4800);
        chk_cur("ff1");
        for (int i = 0; i < 81; i++) begin
            send(8'($urandom_range(33, 126)));
            wait_idle(n);
        end
        chk("wrap_adr", wr_adr_q[$], 80);
        chk_cur("wrap");
        send(8'h08);
        chk_cur("bs1");
        acc0 = acc_cnt;
        send(8'h08);
        wait_idle(n);
        chk("bs0_acc", acc_cnt - acc0, 0);
        chk_cur("bs0");
        chk_scr("scr3");

        // random stream
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 9))
                0: b = 8'h0D;
                1: b = 8'h0A;
                2: b = 8'h08;
                default: b = 8'($urandom_range(32, 255));
            endcase
            send(b);
            wait_idle(n);
            chk_cur("rnd");
        end
        chk_scr("scr_rnd");

        // 5: stalled ack, byte held valid across busy period
        nq = wr_adr_q.size();
        a0 = m_row * 80 + m_col;
        c0 = m_col;
        r0 = m_row;
        @(negedge clk_25mhz);
        ack_hold = 1'b1;
        char_i = 8'h5A;
        char_valid_i = 1'b1;
        @(posedge clk_25mhz);
        #1;
        char_i = 8'h59;
        model_put(8'h5A);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_25mhz);
            chk("hold_adr", int'(adr_o), a0);
            chk("hold_dat", int'(dat_o), 'h5A);
            chk("hold_stb", int'(stb_o), 1);
            chk("hold_we", int'(we_o), 1);
            chk("hold_col", int'(cursor_col_o), c0);
            chk("hold_row", int'(cursor_row_o), r0);
            chk("hold_rdy", int'(char_ready_o), 0);
        end
        ack_hold = 1'b0;
        n = 0;
        @(negedge clk_25mhz);
        while (!char_ready_o && n < 100) begin
            @(negedge clk_25mhz);
            n++;
        end
        if (n >= 100) chk("hold_tmo", int'(char_ready_o), 1);
        chk_cur("hold_done");
        @(posedge clk_25mhz);
        #1;
        char_valid_i = 1'b0;
        model_put(8'h59);
        wait_idle(n);
        repeat (5) @(negedge clk_25mhz);
        chk("once_wr", wr_adr_q.size() - nq, 2);
        chk_cur("once");
        chk_scr("scr5");

        // 4: scroll from the last row
        while (m_row < 59) send(8'h0A);
        chk_cur("bottom");
        for (int i = 0; i < 4800; i++) begin
            mem[i] = 8'(i);
            scr[i] = 8'(i);
        end
        wr_adr_q.delete();
        wr_dat_q.delete();
        send(8'h0A);
        wait_idle(n);
        chk("scr_cyc", n, 3 * 4720 + 80);
        chk("scr_wr", wr_adr_q.size(), 4800);
        bad = 0;
        for (int i = 0; i < 4720; i++) if (mem[i] !== 8'(i + 80)) bad++;
        chk("scr_copy", bad, 0);
        bad = 0;
        for (int i = 4720; i < 4800; i++) if (mem[i] !== 8'h20) bad++;
        chk("scr_fill", bad, 0);
        chk_scr("scr4");
        chk_cur("scroll");

        // 6: reset mid-scroll, then form feed
        @(negedge clk_25mhz);
        char_i = 8'h0A;
        char_valid_i = 1'b1;
        @(posedge clk_25mhz);
        #1;
        char_valid_i = 1'b0;
        repeat (100) @(negedge clk_25mhz);
        #5;
        rst_i = 1'b0;
        #1;
        chk("arst_stb", int'(stb_o), 0);
        chk("arst_busy", int'(busy_o), 1);
        chk("arst_rdy", int'(char_ready_o), 0);
        m_blank();
        chk_cur("arst");
        repeat (2) @(negedge clk_25mhz);
        wr_adr_q.delete();
        wr_dat_q.delete();
        rst_i = 1'b1;
        wait_idle(n);
        chk_clear("reclr");
        chk_scr("scr6");
        for (int i = 0; i < 7; i++) begin
            send(8'($urandom_range(33, 126)));
            wait_idle(n);
        end
        send(8'h0A);
        wr_adr_q.delete();
        wr_dat_q.delete();
        send(8'h0C);
        wait_idle(n);
        chk("ff2_cyc", n, 4800);
        chk_clear("ff2");
        chk_cur("ff2");
        chk_scr("scr_ff");
        chk("sel", sel_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
